// File: rtl/w0rm_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : w0rm_memory_arbiter
// Brief    : Two-master round-robin arbiter sharing one W0RM memory port, one
//            outstanding transaction, registered request and response timeout.
//            Optional macro W0RM_MEMARB_STATS_EN adds saturating grant/timeout
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module w0rm_memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset_n,

    input  logic                  m0_valid_i,
    input  logic                  m0_read_i,
    input  logic                  m0_write_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic [USER_WIDTH-1:0] m0_user_i,
    output logic                  m0_accept_o,
    output logic                  m0_valid_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic [USER_WIDTH-1:0] m0_user_o,
    output logic                  m0_error_o,

    input  logic                  m1_valid_i,
    input  logic                  m1_read_i,
    input  logic                  m1_write_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic [USER_WIDTH-1:0] m1_user_i,
    output logic                  m1_accept_o,
    output logic                  m1_valid_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic [USER_WIDTH-1:0] m1_user_o,
    output logic                  m1_error_o,

`ifdef W0RM_MEMARB_STATS_EN
    output logic [31:0]           stat_grant0_o,
    output logic [31:0]           stat_grant1_o,
    output logic [15:0]           stat_timeout_o,
`endif

    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [USER_WIDTH-1:0] mem_user_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [USER_WIDTH-1:0] mem_user_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_last_grant;
    logic       r_owner;
    logic [7:0] r_count;

    logic       w_live0;
    logic       w_live1;
    logic       w_grant;
    logic       w_sel;
    logic       w_timeout;
    logic       w_timeout_fire;

    assign w_live0        = m0_valid_i & (m0_read_i | m0_write_i);
    assign w_live1        = m1_valid_i & (m1_read_i | m1_write_i);
    assign w_timeout      = (r_count == c_TIMEOUT_LAST);
    assign w_timeout_fire = (r_state == S_WAIT) & ~mem_valid_i & w_timeout;

    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accept is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_sel        = 1'b0;
        m0_accept_o  = 1'b0;
        m1_accept_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant = cpu_reset_n & (w_live0 | w_live1);
                w_sel   = (w_live0 & w_live1) ? ~r_last_grant : w_live1;
                m0_accept_o = w_grant & ~w_sel;
                m1_accept_o = w_grant &  w_sel;
                if (w_grant) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (mem_valid_i || w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_count      <= '0;
            mem_valid_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_user_o   <= '0;
            m0_valid_o   <= 1'b0;
            m0_error_o   <= 1'b0;
            m0_data_o    <= '0;
            m0_user_o    <= '0;
            m1_valid_o   <= 1'b0;
            m1_error_o   <= 1'b0;
            m1_data_o    <= '0;
            m1_user_o    <= '0;
        end else begin
            m0_valid_o <= 1'b0;
            m0_error_o <= 1'b0;
            m1_valid_o <= 1'b0;
            m1_error_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        mem_valid_o  <= 1'b1;
                        mem_read_o   <= w_sel ? m1_read_i  : m0_read_i;
                        mem_write_o  <= w_sel ? m1_write_i : m0_write_i;
                        mem_addr_o   <= w_sel ? m1_addr_i  : m0_addr_i;
                        mem_data_o   <= w_sel ? m1_data_i  : m0_data_i;
                        mem_user_o   <= w_sel ? m1_user_i  : m0_user_i;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                    end
                end
                S_ISSUE: begin
                    mem_valid_o <= 1'b0;
                    r_count     <= '0;
                end
                S_WAIT: begin
                    if (mem_valid_i) begin
                        if (r_owner) begin
                            m1_valid_o <= 1'b1;
                            m1_data_o  <= mem_data_i;
                            m1_user_o  <= mem_user_i;
                        end else begin
                            m0_valid_o <= 1'b1;
                            m0_data_o  <= mem_data_i;
                            m0_user_o  <= mem_user_i;
                        end
                    end else if (w_timeout) begin
                        // Error response echoes the tag still held on mem_user_o.
                        if (r_owner) begin
                            m1_valid_o <= 1'b1;
                            m1_error_o <= 1'b1;
                            m1_data_o  <= '0;
                            m1_user_o  <= mem_user_o;
                        end else begin
                            m0_valid_o <= 1'b1;
                            m0_error_o <= 1'b1;
                            m0_data_o  <= '0;
                            m0_user_o  <= mem_user_o;
                        end
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef W0RM_MEMARB_STATS_EN
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            stat_grant0_o  <= '0;
            stat_grant1_o  <= '0;
            stat_timeout_o <= '0;
        end else begin
            if (m0_accept_o && (stat_grant0_o != '1)) begin
                stat_grant0_o <= stat_grant0_o + 32'd1;
            end
            if (m1_accept_o && (stat_grant1_o != '1)) begin
                stat_grant1_o <= stat_grant1_o + 32'd1;
            end
            if (w_timeout_fire && (stat_timeout_o != '1)) begin
                stat_timeout_o <= stat_timeout_o + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_w0rm_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_w0rm_memory_arbiter
// Brief    : Self-checking bench for w0rm_memory_arbiter (directed scenarios
//            plus randomized traffic against a cycle-arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_w0rm_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int UW = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          m0_valid_i, m0_read_i, m0_write_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i;
    logic [UW-1:0] m0_user_i;
    logic          m0_accept_o, m0_valid_o, m0_error_o;
    logic [DW-1:0] m0_data_o;
    logic [UW-1:0] m0_user_o;
    logic          m1_valid_i, m1_read_i, m1_write_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic [UW-1:0] m1_user_i;
    logic          m1_accept_o, m1_valid_o, m1_error_o;
    logic [DW-1:0] m1_data_o;
    logic [UW-1:0] m1_user_o;
    logic          mem_valid_o, mem_read_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [UW-1:0] mem_user_o;
    logic          mem_valid_i;
    logic [DW-1:0] mem_data_i;
    logic [UW-1:0] mem_user_i;
`ifdef W0RM_MEMARB_STATS_EN
    logic [31:0]   stat_grant0_o, stat_grant1_o;
    logic [15:0]   stat_timeout_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    w0rm_memory_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .mem_clk(clk), .cpu_reset_n(rst_n),
        .m0_valid_i(m0_valid_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_user_i(m0_user_i),
        .m0_accept_o(m0_accept_o), .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o),
        .m0_user_o(m0_user_o), .m0_error_o(m0_error_o),
        .m1_valid_i(m1_valid_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_user_i(m1_user_i),
        .m1_accept_o(m1_accept_o), .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o),
        .m1_user_o(m1_user_o), .m1_error_o(m1_error_o),
`ifdef W0RM_MEMARB_STATS_EN
        .stat_grant0_o(stat_grant0_o), .stat_grant1_o(stat_grant1_o),
        .stat_timeout_o(stat_timeout_o),
`endif
        .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i)
    );

    task automatic clear_inputs();
        m0_valid_i = 1'b0; m0_read_i = 1'b0; m0_write_i = 1'b0;
        m0_addr_i = '0; m0_data_i = '0; m0_user_i = '0;
        m1_valid_i = 1'b0; m1_read_i = 1'b0; m1_write_i = 1'b0;
        m1_addr_i = '0; m1_data_i = '0; m1_user_i = '0;
        mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m1_valid_i = 1'b1; m1_write_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({m0_accept_o, m0_valid_o, m0_data_o, m0_user_o, m0_error_o,
             m1_accept_o, m1_valid_o, m1_data_o, m1_user_o, m1_error_o,
             mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got mem_valid=%b m0_acc=%b m1_acc=%b addr=%h, required all 0",
                     mem_valid_o, m0_accept_o, m1_accept_o, mem_addr_o);
        end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        @(posedge clk); #1;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h4000_0008; m0_user_i = 32'h0000_00A5;
        @(negedge clk);
        n_vec++;
        if ({m1_accept_o, m0_accept_o} !== 2'b01) begin
            n_err++; $display("FAIL single_accept: got %b required 01", {m1_accept_o, m0_accept_o});
        end
        @(posedge clk); #1;
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_user_o} !== {3'b110, 32'h4000_0008, 32'h0000_00A5}) begin
            n_err++; $display("FAIL single_issue: got v=%b r=%b w=%b a=%h u=%h required 1 1 0 40000008 000000a5",
                              mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_user_o);
        end
        @(posedge clk); #1;
        mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; mem_user_i = 32'h0000_00A5;
        @(negedge clk);
        n_vec++;
        if ({mem_valid_o, m0_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL single_wait: got mem_valid=%b m0_valid=%b required 0 0", mem_valid_o, m0_valid_o);
        end
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m0_valid_o, m0_error_o, m0_data_o, m0_user_o} !== {2'b10, 32'hDEAD_BEEF, 32'h0000_00A5}) begin
            n_err++; $display("FAIL single_resp: got v=%b e=%b d=%h u=%h required 1 0 deadbeef 000000a5",
                              m0_valid_o, m0_error_o, m0_data_o, m0_user_o);
        end
        n_vec++;
        if ({m1_accept_o, m1_valid_o, m1_error_o, m1_data_o, m1_user_o} !== '0) begin
            n_err++; $display("FAIL single_m1_quiet: got v=%b d=%h u=%h required 0", m1_valid_o, m1_data_o, m1_user_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if ({m0_valid_o, m0_data_o} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL single_hold: got v=%b d=%h required 0 deadbeef", m0_valid_o, m0_data_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [UW-1:0] cur_user [2];
        logic [UW-1:0] served;
        int pg;
        apply_reset();
        cur_user[0] = 32'h10; cur_user[1] = 32'h20;
        @(posedge clk); #1;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h100; m0_user_i = cur_user[0];
        m1_valid_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h200; m1_data_i = 32'h55; m1_user_i = cur_user[1];
        served = '0;
        pg = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_vec++;
                if ({(pg == 0 ? m0_valid_o : m1_valid_o), (pg == 0 ? m1_valid_o : m0_valid_o),
                     (pg == 0 ? m0_user_o : m1_user_o), (pg == 0 ? m0_data_o : m1_data_o)}
                    !== {2'b10, served, 32'hC0DE_0000 + 32'(k - 1)}) begin
                    n_err++; $display("FAIL simul_resp%0d: got m0v=%b m1v=%b m0u=%h m1u=%h required owner m%0d user %h",
                                      k - 1, m0_valid_o, m1_valid_o, m0_user_o, m1_user_o, pg, served);
                end
            end
            if (k == 4) break;
            pg = k % 2;
            n_vec++;
            if ({m1_accept_o, m0_accept_o} !== (pg == 0 ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL simul_grant%0d: got %b required m%0d", k, {m1_accept_o, m0_accept_o}, pg);
            end
            served = cur_user[pg];
            @(posedge clk); #1;
            cur_user[pg] = cur_user[pg] + 32'h1;
            if (pg == 0) m0_user_i = cur_user[0]; else m1_user_i = cur_user[1];
            @(negedge clk);
            n_vec++;
            if ({mem_valid_o, mem_user_o} !== {1'b1, served}) begin
                n_err++; $display("FAIL simul_issue%0d: got v=%b u=%h required 1 %h", k, mem_valid_o, mem_user_o, served);
            end
            @(posedge clk); #1;
            mem_valid_i = 1'b1; mem_data_i = 32'hC0DE_0000 + 32'(k); mem_user_i = served;
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        @(posedge clk); #1;
        m1_valid_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h1000_0000; m1_data_i = 32'h1234; m1_user_i = 32'h77;
        @(negedge clk);
        n_vec++;
        if ({m1_accept_o, m0_accept_o} !== 2'b10) begin
            n_err++; $display("FAIL to_accept: got %b required 10", {m1_accept_o, m0_accept_o});
        end
        @(posedge clk); #1;
        m1_valid_i = 1'b0; m1_write_i = 1'b0;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h300; m0_user_i = 32'h55;
        for (int i = 1; i <= TO + 1; i++) begin
            @(negedge clk);
            n_vec++;
            if ({m0_accept_o, m1_valid_o, m1_error_o, mem_valid_o} !== {3'b000, (i == 1)}) begin
                n_err++; $display("FAIL to_wait%0d: got acc0=%b v1=%b e1=%b memv=%b", i, m0_accept_o, m1_valid_o, m1_error_o, mem_valid_o);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_vec++;
        if ({m1_valid_o, m1_error_o, m1_data_o, m1_user_o, m0_valid_o, m0_accept_o} !== {2'b11, 32'h0, 32'h77, 2'b01}) begin
            n_err++; $display("FAIL to_error: got v=%b e=%b d=%h u=%h v0=%b acc0=%b required 1 1 0 77 0 1",
                              m1_valid_o, m1_error_o, m1_data_o, m1_user_o, m0_valid_o, m0_accept_o);
        end
        @(posedge clk); #1;
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_valid_o, mem_addr_o, mem_user_o} !== {1'b1, 32'h300, 32'h55}) begin
            n_err++; $display("FAIL to_next_issue: got v=%b a=%h u=%h required 1 300 55", mem_valid_o, mem_addr_o, mem_user_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        @(posedge clk); #1;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'hABCD_0000; m0_user_i = 32'h99;
        @(posedge clk); #1;
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m0_accept_o, m0_valid_o, m0_data_o, m0_user_o, m0_error_o,
             m1_accept_o, m1_valid_o, m1_data_o, m1_user_o, m1_error_o,
             mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o} !== '0) begin
            n_err++; $display("FAIL midwait_async_clear: got addr=%h user=%h read=%b required all 0", mem_addr_o, mem_user_o, mem_read_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TO + 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_vec++;
            if ({m0_valid_o, m1_valid_o, mem_valid_o} !== 3'b000) begin
                n_err++; $display("FAIL midwait_no_pulse%0d: got v0=%b v1=%b memv=%b required 0", i, m0_valid_o, m1_valid_o, mem_valid_o);
            end
        end
        @(posedge clk); #1;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m1_valid_i = 1'b1; m1_read_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({m1_accept_o, m0_accept_o} !== 2'b01) begin
            n_err++; $display("FAIL midwait_regrant: got %b required 01", {m1_accept_o, m0_accept_o});
        end
        clear_inputs();
    endtask

    task automatic test_ignored();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            m0_valid_i = 1'b1; m0_read_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = $urandom;
            m1_valid_i = (i % 2 == 1); m1_addr_i = $urandom;
            @(negedge clk);
            n_vec++;
            if ({m0_accept_o, m1_accept_o, mem_valid_o} !== 3'b000) begin
                n_err++; $display("FAIL ignored%0d: got acc0=%b acc1=%b memv=%b required 0", i, m0_accept_o, m1_accept_o, mem_valid_o);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit            pend [2];
        logic [AW-1:0] p_addr [2];
        logic [DW-1:0] p_data [2];
        logic [UW-1:0] p_user [2];
        bit            p_rd [2];
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_data, r_data;
        logic [UW-1:0] t_user, r_user;
        bit            t_rd, exp_err;
        int idle_from, acc_cyc, mem_cyc, resp_cyc, owner, lastg, win, d;
        int g0, g1, nto;
        apply_reset();
        pend[0] = 0; pend[1] = 0;
        lastg = 1; idle_from = 0; acc_cyc = -10; mem_cyc = -1; resp_cyc = -1; owner = 0;
        exp_err = 0; t_addr = '0; t_data = '0; t_user = '0; t_rd = 0; r_data = '0; r_user = '0;
        g0 = 0; g1 = 0; nto = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (c < 600 && !pend[m] && $urandom_range(2) == 0) begin
                    pend[m] = 1; p_addr[m] = $urandom; p_data[m] = $urandom;
                    p_user[m] = $urandom; p_rd[m] = $urandom_range(1) == 1;
                end
            end
            m0_valid_i = pend[0]; m0_read_i = pend[0] & p_rd[0]; m0_write_i = pend[0] & ~p_rd[0];
            m0_addr_i = p_addr[0]; m0_data_i = p_data[0]; m0_user_i = p_user[0];
            m1_valid_i = pend[1]; m1_read_i = pend[1] & p_rd[1]; m1_write_i = pend[1] & ~p_rd[1];
            m1_addr_i = p_addr[1]; m1_data_i = p_data[1]; m1_user_i = p_user[1];
            if (c == mem_cyc) begin
                mem_valid_i = 1'b1; mem_data_i = $urandom; mem_user_i = t_user;
                r_data = mem_data_i; r_user = t_user;
            end else if (c >= idle_from || c == acc_cyc + 1) begin
                mem_valid_i = ($urandom_range(3) == 0); mem_data_i = $urandom; mem_user_i = $urandom;
            end else begin
                mem_valid_i = 1'b0;
            end
            @(negedge clk);
            win = -1;
            if (c >= idle_from && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) win = 1 - lastg;
                else win = pend[0] ? 0 : 1;
            end
            n_vec++;
            if ({m1_accept_o, m0_accept_o} !== {(win == 1), (win == 0)}) begin
                n_err++; $display("FAIL rand_accept c=%0d: got %b required m%0d", c, {m1_accept_o, m0_accept_o}, win);
            end
            n_vec++;
            if (mem_valid_o !== (c == acc_cyc + 1)) begin
                n_err++; $display("FAIL rand_memvalid c=%0d: got %b", c, mem_valid_o);
            end
            if (c == acc_cyc + 1) begin
                n_vec++;
                if ({mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o} !== {t_rd, ~t_rd, t_addr, t_data, t_user}) begin
                    n_err++; $display("FAIL rand_issue c=%0d: got a=%h d=%h u=%h r=%b required %h %h %h %b",
                                      c, mem_addr_o, mem_data_o, mem_user_o, mem_read_o, t_addr, t_data, t_user, t_rd);
                end
            end
            n_vec++;
            if ({m0_valid_o, m0_error_o, m1_valid_o, m1_error_o} !==
                {(c == resp_cyc && owner == 0), (c == resp_cyc && owner == 0 && exp_err),
                 (c == resp_cyc && owner == 1), (c == resp_cyc && owner == 1 && exp_err)}) begin
                n_err++; $display("FAIL rand_resp_strobe c=%0d: got v0=%b e0=%b v1=%b e1=%b, required owner m%0d at %0d err=%b",
                                  c, m0_valid_o, m0_error_o, m1_valid_o, m1_error_o, owner, resp_cyc, exp_err);
            end
            if (c == resp_cyc) begin
                n_vec++;
                if ({(owner == 0 ? m0_data_o : m1_data_o), (owner == 0 ? m0_user_o : m1_user_o)} !==
                    {(exp_err ? 32'h0 : r_data), (exp_err ? t_user : r_user)}) begin
                    n_err++; $display("FAIL rand_resp_data c=%0d: got d0=%h u0=%h d1=%h u1=%h", c, m0_data_o, m0_user_o, m1_data_o, m1_user_o);
                end
            end
            if (win >= 0) begin
                t_addr = p_addr[win]; t_data = p_data[win]; t_user = p_user[win]; t_rd = p_rd[win];
                pend[win] = 0; lastg = win; owner = win; acc_cyc = c;
                if (win == 0) g0++; else g1++;
                d = $urandom_range(TO + 3, 0);
                if (d < TO) begin
                    mem_cyc = c + 2 + d; resp_cyc = c + 3 + d; exp_err = 0;
                end else begin
                    mem_cyc = -1; resp_cyc = c + 2 + TO; exp_err = 1; nto++;
                end
                idle_from = resp_cyc;
            end
        end
`ifdef W0RM_MEMARB_STATS_EN
        n_vec++;
        if ({stat_grant0_o, stat_grant1_o, stat_timeout_o} !== {32'(g0), 32'(g1), 16'(nto)}) begin
            n_err++; $display("FAIL rand_stats: got g0=%0d g1=%0d to=%0d required %0d %0d %0d",
                              stat_grant0_o, stat_grant1_o, stat_timeout_o, g0, g1, nto);
        end
`endif
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_timeout();
        test_reset_mid_wait();
        test_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/w0rm_memory_arbiter.md
Name: w0rm_memory_arbiter

Overview:
- Two-master, single-slave arbiter that shares one W0RM memory block port between requesters (e.g. instruction fetch and load/store unit).
- Round-robin grant, one outstanding transaction at a time, registered request toward memory.
- Routes the response back to the granted master.
- Times out requests that never complete, e.g. an address outside the block's decode window.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- USER_WIDTH, 32, user/tag sideband width, passed through unchanged.
- TIMEOUT_CYCLES, 15, cycles in WAIT before an error response; legal range 1..255.

Ports:
- mem_clk  in  1  clock.
- cpu_reset_n  in  1  reset, asynchronous, active-low.
- mN_valid_i  in  1  request strobe (N = 0, 1; same set for each master).
- mN_read_i, mN_write_i  in  1 each  operation type.
- mN_addr_i  in  ADDR_WIDTH  byte address.
- mN_data_i  in  DATA_WIDTH  write data.
- mN_user_i  in  USER_WIDTH  tag.
- mN_accept_o  out  1  request taken this cycle.
- mN_valid_o  out  1  response strobe, one cycle.
- mN_data_o  out  DATA_WIDTH  read data.
- mN_user_o  out  USER_WIDTH  returned tag.
- mN_error_o  out  1  response is a timeout error; qualified by mN_valid_o.
- mem_valid_o, mem_read_o, mem_write_o  out  1 each  request to memory.
- mem_addr_o  out  ADDR_WIDTH  request address to memory.
- mem_data_o  out  DATA_WIDTH  write data to memory.
- mem_user_o  out  USER_WIDTH  tag to memory.
- mem_valid_i  in  1  memory response strobe.
- mem_data_i  in  DATA_WIDTH  memory read data.
- mem_user_i  in  USER_WIDTH  memory returned tag.

Behaviour:
- Reset (async, cpu_reset_n=0):
  - All outputs 0.
  - State IDLE, last_grant=1 (so m0 wins the first tie), timeout counter 0.
- A request is "live" when mN_valid_i=1 and (read or write)=1. A valid with neither read nor write is ignored: never accepted, no response.
- IDLE:
  - If any request is live, grant it. If both are live, grant the master that is not last_grant.
  - Assert mN_accept_o combinationally that cycle for the granted master only.
  - Register addr/data/read/write/user onto the mem_* outputs with mem_valid_o=1 for exactly the next cycle.
  - Record the owner, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - mem_valid_o=1 with the latched fields.
  - Next state WAIT; counter cleared.
- WAIT:
  - mem_valid_o=0; mem_addr_o/data/user hold their values.
  - On mem_valid_i=1: copy mem_data_i and mem_user_i to owner's mN_data_o and mN_user_o, pulse owner's mN_valid_o for one cycle with error=0, go to IDLE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES: pulse owner's mN_valid_o with mN_error_o=1, data 0, user = latched request user; go to IDLE.
- Response latency:
  - Request accepted in cycle T, memory sees mem_valid_o in T+1 and responds in T+2, master sees mN_valid_o in T+3.
  - Next acceptance no earlier than T+3 (response and new accept may share the cycle).
- mem_valid_i in IDLE or ISSUE: ignored and dropped.
- Non-owner mN_valid_o and mN_error_o stay 0 at all times.
- Data outputs hold their last value between responses.
- Reset mid-transaction: the transaction is abandoned, no response pulse, and last_grant returns to 1.
- Masters must hold request fields stable until accept.

Optional Feature:
- Macro: W0RM_MEMARB_STATS_EN.
- When defined:
  - Adds outputs stat_grant0_o and stat_grant1_o (32 bits each, counting accepts per master) and stat_timeout_o (16 bits, counting error responses).
  - All counters saturate, never wrap, and reset to 0.
- When undefined: no such ports, no counter logic.

Test Plan:
- Single read: m0 reads 0x4000_0008, memory returns 0xDEADBEEF one cycle after mem_valid_o -> m0_valid_o at T+3 with data 0xDEADBEEF and user echoed; m1 outputs stay 0.
- Simultaneous: m0 and m1 both live from reset for 4 transactions -> grants m0, m1, m0, m1; each response routed to the correct master with the correct user tag.
- Timeout: m1 writes 0x1000_0000 and memory never responds, TIMEOUT_CYCLES=15 -> m1_valid_o=1 with m1_error_o=1 exactly 15 cycles after entering WAIT; the arbiter then accepts the pending m0 request.
- Reset mid-WAIT: drop cpu_reset_n during WAIT -> all outputs 0 immediately (asynchronously), no response pulse afterwards, next simultaneous request grants m0.
- Ignored request: m0_valid_i=1 with read=write=0 for 10 cycles -> no accept, mem_valid_o stays 0.
- Stats (with W0RM_MEMARB_STATS_EN): 3 m0 grants, 2 m1 grants, 1 timeout -> stat_grant0_o=3, stat_grant1_o=2, stat_timeout_o=1.
